// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word block fills and same-cycle hits.
// Optional hit/miss statistics ports are compiled in when ICACHE_STATS_EN is defined.
module icache_assoc #(
  parameter int unsigned SETS        = 8,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned WOFF   = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX    = $clog2(SETS);
  localparam int unsigned TAG_W  = 30 - WOFF - IDX;
  localparam int unsigned WOFF_W = (WOFF > 0) ? WOFF : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_e;

  state_e state_q, state_d;

  logic [IDX-1:0]    req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WOFF_W-1:0] req_woff;

  logic              valid_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [31:0]       data_q  [SETS][WAYS][BLOCK_WORDS];
  logic [WAY_W-1:0]  vptr_q  [SETS];

  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX-1:0]    miss_idx_q;
  logic [WAY_W-1:0]  victim_q;
  logic              by_ptr_q;
  logic [WOFF_W-1:0] cnt_q;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              use_ptr;
  logic              start_fill;
  logic              accept;
  logic              last;

  logic unused_addr;
  assign unused_addr = &{1'b0, imemaddr[1:0]};

  assign req_idx  = IDX'(imemaddr >> (2 + WOFF));
  assign req_tag  = imemaddr[31 -: TAG_W];
  assign req_woff = (BLOCK_WORDS > 1) ? WOFF_W'(imemaddr >> 2) : '0;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][WAY_W'(w)] && (tag_q[req_idx][WAY_W'(w)] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins; pointer is the fallback.
  always_comb begin
    victim  = vptr_q[req_idx];
    use_ptr = 1'b1;
    for (int unsigned w = WAYS; w > 0; w--) begin
      if (!valid_q[req_idx][WAY_W'(w - 1)]) begin
        victim  = WAY_W'(w - 1);
        use_ptr = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          state_d    = FILL;
          start_fill = 1'b1;
        end
      end
      FILL: begin
        if (!iwait) begin
          accept = 1'b1;
          if (cnt_q == WOFF_W'(BLOCK_WORDS - 1)) begin
            last    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ihit     = (state_q == IDLE) && imemREN && hit;
  assign imemload = ihit ? data_q[req_idx][hit_way][req_woff] : '0;
  assign iREN     = (state_q == FILL);
  assign iaddr    = iREN ? ((32'(miss_tag_q) << (2 + WOFF + IDX)) |
                            (32'(miss_idx_q) << (2 + WOFF)) |
                            (32'(cnt_q) << 2))
                         : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q    <= '{default: '0};
      tag_q      <= '{default: '0};
      data_q     <= '{default: '0};
      vptr_q     <= '{default: '0};
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      victim_q   <= '0;
      by_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (start_fill) begin
        miss_tag_q               <= req_tag;
        miss_idx_q               <= req_idx;
        victim_q                 <= victim;
        by_ptr_q                 <= use_ptr;
        cnt_q                    <= '0;
        valid_q[req_idx][victim] <= 1'b0;
      end
      if (accept) begin
        data_q[miss_idx_q][victim_q][cnt_q] <= iload;
        if (last) begin
          cnt_q                           <= '0;
          tag_q[miss_idx_q][victim_q]     <= miss_tag_q;
          valid_q[miss_idx_q][victim_q]   <= 1'b1;
          if (by_ptr_q && (WAYS > 1))
            vptr_q[miss_idx_q] <= vptr_q[miss_idx_q] + WAY_W'(1);
        end else begin
          cnt_q <= cnt_q + WOFF_W'(1);
        end
      end
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit)       hit_count  <= hit_count + 32'd1;
      if (start_fill) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
